// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB command master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  // One-hot select for slave index idx; callers truncate to their PSEL width.
  function automatic logic [31:0] onehot_sel(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB master bus signals, grouped for the master.
interface apb_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int PSEL_WIDTH = 1
);
  localparam int SEL_WIDTH = $clog2(PSEL_WIDTH) + 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [SEL_WIDTH-1:0]  cmd_sel;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic [PSEL_WIDTH-1:0] PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata, rsp_ready,
           PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSELx, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata, rsp_ready,
           PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSELx, PENABLE, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS wait-state counter; flags when TIMEOUT_CYCLES waits have elapsed.
module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic limit_reached
);
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT)) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

  assign limit_reached = (count_reg == LIMIT);

endmodule

// File: rtl/apb_cmd_master.sv
// APB master: turns one cmd_* request into an APB transfer and returns a rsp_* result.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int PSEL_WIDTH     = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                PCLK,
  input logic                PRESETn,
  apb_cmd_master_if.master   bus
);
  localparam int SEL_WIDTH = $clog2(PSEL_WIDTH) + 1;
  localparam logic [SEL_WIDTH-1:0] SEL_LIMIT = SEL_WIDTH'(PSEL_WIDTH);

  apb_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic [PSEL_WIDTH-1:0] psel_reg, psel_next;
  logic                  penable_reg, penable_next;
  logic                  pwrite_reg, pwrite_next;
  logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic                  rsp_timeout_reg, rsp_timeout_next;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_limit;

  // The limit is seen one edge after the last counted wait state, so a slave that
  // answers on that edge still completes normally.
  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk          (PCLK),
    .rst_n        (PRESETn),
    .clear        (cnt_clear),
    .enable       (cnt_enable),
    .limit_reached(cnt_limit)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg       <= IDLE;
      paddr_reg       <= '0;
      psel_reg        <= '0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      pwdata_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      paddr_reg       <= paddr_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      pwrite_reg      <= pwrite_next;
      pwdata_reg      <= pwdata_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    paddr_next       = paddr_reg;
    psel_next        = psel_reg;
    penable_next     = penable_reg;
    pwrite_next      = pwrite_reg;
    pwdata_next      = pwdata_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;
    cnt_clear        = 1'b0;
    cnt_enable       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_sel < SEL_LIMIT) begin
            state_next   = SETUP;
            paddr_next   = bus.cmd_addr;
            pwrite_next  = bus.cmd_write;
            pwdata_next  = bus.cmd_wdata;
            psel_next    = PSEL_WIDTH'(onehot_sel(32'(bus.cmd_sel)));
            penable_next = 1'b0;
          end else begin
            // Unmapped slave index: answer with an error, never touch the bus.
            state_next       = RESP;
            rsp_valid_next   = 1'b1;
            rsp_err_next     = 1'b1;
            rsp_timeout_next = 1'b0;
            rsp_rdata_next   = '0;
          end
        end
      end

      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
        cnt_clear    = 1'b1;
      end

      ACCESS: begin
        if (bus.PREADY) begin
          state_next       = RESP;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = pwrite_reg ? '0 : bus.PRDATA;
          rsp_err_next     = bus.PSLVERR;
          rsp_timeout_next = 1'b0;
          psel_next        = '0;
          penable_next     = 1'b0;
        end else if (cnt_limit) begin
          state_next       = RESP;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = '0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          psel_next        = '0;
          penable_next     = 1'b0;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
        end
      end

      default: begin
        state_next       = IDLE;
        paddr_next       = '0;
        psel_next        = '0;
        penable_next     = 1'b0;
        pwrite_next      = 1'b0;
        pwdata_next      = '0;
        rsp_valid_next   = 1'b0;
        rsp_rdata_next   = '0;
        rsp_err_next     = 1'b0;
        rsp_timeout_next = 1'b0;
        cnt_clear        = 1'b1;
      end
    endcase
  end

  assign bus.cmd_ready   = (state_reg == IDLE) && PRESETn;
  assign bus.PADDR       = paddr_reg;
  assign bus.PSELx       = psel_reg;
  assign bus.PENABLE     = penable_reg;
  assign bus.PWRITE      = pwrite_reg;
  assign bus.PWDATA      = pwdata_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed plus randomized transfers against a cycle-count/result model of the APB master.
module tb_apb_cmd_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int PW = 2;
  localparam int TO = 4;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_txn = 0;

  always #5 PCLK = ~PCLK;

  apb_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PSEL_WIDTH(PW)) bus ();

  apb_cmd_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PSEL_WIDTH(PW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  logic [127:0] all_outs;
  assign all_outs = {24'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                     bus.rsp_timeout, bus.PADDR, bus.PSELx, bus.PENABLE, bus.PWRITE,
                     bus.PWDATA};

  typedef struct packed {
    logic          err;
    logic          tmo;
    logic [31:0]   rdata;
    logic [7:0]    n_setup;
    logic [7:0]    n_access;
    logic [PW-1:0] psel;
  } exp_t;

  // Result of a transfer whose slave holds PREADY low for `waits` ACCESS cycles.
  function automatic exp_t model(input logic wr, input int sel, input logic [31:0] prdata,
                                 input logic slverr, input int waits);
    exp_t e;
    e = '0;
    if (sel >= PW) begin
      e.err = 1'b1;
    end else begin
      e.psel    = PW'(1) << sel;
      e.n_setup = 8'd1;
      if (waits > TO) begin
        e.err      = 1'b1;
        e.tmo      = 1'b1;
        e.n_access = 8'(TO + 1);
      end else begin
        e.err      = slverr;
        e.n_access = 8'(waits + 1);
        e.rdata    = wr ? 32'd0 : prdata;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_noise();
    bus.PREADY  = 1'($urandom_range(0, 1));
    bus.PRDATA  = $urandom;
    bus.PSLVERR = 1'($urandom_range(0, 1));
  endtask

  task automatic run_txn(input logic wr, input logic [1:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] prdata,
                         input logic slverr, input int waits, input int hold);
    exp_t         e;
    int           cyc;
    int           n_set;
    int           n_acc;
    logic         got;
    logic [66:0]  bus_exp;
    e       = model(wr, int'(sel), prdata, slverr, waits);
    bus_exp = {addr, wr, wdata, e.psel};
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_sel   = sel;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    drive_noise();
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    check("busy_cmd_ready", bus.cmd_ready, 0);
    cyc = 0; n_set = 0; n_acc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
      end else begin
        if (bus.PSELx != '0) begin
          check("bus_fields", {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSELx}, bus_exp);
        end
        if (bus.PSELx != '0 && bus.PENABLE) begin
          n_acc++;
          bus.PREADY  = (n_acc > waits);
          bus.PRDATA  = (n_acc > waits) ? prdata : $urandom;
          bus.PSLVERR = (n_acc > waits) ? slverr : 1'($urandom_range(0, 1));
        end else begin
          if (bus.PSELx != '0) n_set++;
          drive_noise();
        end
        @(posedge PCLK); #1;
        cyc++;
      end
    end
    check("rsp_arrived", got, 1);
    check("rsp_fields", {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {e.err, e.tmo, e.rdata});
    check("latency", 128'(cyc), 128'(e.n_setup + e.n_access));
    check("setup_cycles", 128'(n_set), 128'(e.n_setup));
    check("access_cycles", 128'(n_acc), 128'(e.n_access));
    check("bus_released", {bus.PSELx, bus.PENABLE}, 0);
    for (int h = 0; h < hold; h++) begin
      drive_noise();
      @(posedge PCLK); #1;
      check("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, bus.cmd_ready},
            {1'b1, e.err, e.tmo, e.rdata, 1'b0});
    end
    bus.rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_done", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    n_txn++;
    $display("txn %0d: wr=%0b sel=%0d addr=%h waits=%0d hold=%0d -> err=%0b tmo=%0b rdata=%h lat=%0d",
             n_txn, wr, sel, addr, waits, hold, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, cyc);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_sel   = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;

    #2;
    check("reset_outputs", all_outs, 0);
    #20 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("reset_release", {bus.cmd_ready, bus.rsp_valid, bus.PSELx, bus.PENABLE}, 5'b10000);

    run_txn(1'b1, 2'd0, 32'h10, 32'hA5A5_0001, 32'h0, 1'b0, 0, 0);
    run_txn(1'b0, 2'd1, 32'h24, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1);
    run_txn(1'b0, 2'd0, 32'h30, 32'h1234, 32'h5555_AAAA, 1'b1, 1, 0);
    run_txn(1'b1, 2'd1, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0, 5, 0);
    run_txn(1'b0, 2'd1, 32'h44, 32'h0, 32'h0BAD_C0DE, 1'b0, 4, 0);
    run_txn(1'b0, 2'd3, 32'h50, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 5);
    run_txn(1'b1, 2'd2, 32'h54, 32'h77, 32'h0, 1'b0, 0, 2);

    // Reset pulse in the middle of an ACCESS wait state.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_sel   = 2'd1;
    bus.cmd_addr  = 32'h60;
    bus.cmd_wdata = 32'h99;
    bus.PREADY    = 1'b0;
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    check("pre_reset_access", {bus.PSELx, bus.PENABLE}, 3'b101);
    @(posedge PCLK); #1;
    #2 PRESETn = 1'b0;
    #1;
    check("async_reset", all_outs, 0);
    #3 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("post_reset_idle", {bus.cmd_ready, bus.rsp_valid, bus.PSELx, bus.PENABLE}, 5'b10000);
    run_txn(1'b0, 2'd0, 32'h64, 32'h0, 32'h1357_9BDF, 1'b0, 2, 0);

    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
